// File: rtl/complex_operand_feeder.sv
// complex_operand_feeder: buffers complex operand arrays A/B and streams them pairwise to complex_array_sub_add
// Ports: host write (wr_en/wr_sel/wr_data/wr_clr), run command (cmd_start/cmd_op),
// stream out (a_data/b_data/a_valid/b_valid/start/last/operation, out_ready),
// status (busy/done/a_cnt/b_cnt/wr_err/cmd_err).
// Optional: FEEDER_CONJ_B_EN negates (saturating) the imaginary part of b_data.
module complex_operand_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                wr_clr,
  input  logic                cmd_start,
  input  logic                cmd_op,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] a_data,
  output logic [2*DATA_W-1:0] b_data,
  output logic                a_valid,
  output logic                b_valid,
  output logic                start,
  output logic                last,
  output logic                operation,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         a_cnt,
  output logic [AW:0]         b_cnt,
  output logic                wr_err,
  output logic                cmd_err
);
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FINISH} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [2*DATA_W-1:0] mem_a [DEPTH];
  logic [2*DATA_W-1:0] mem_b [DEPTH];
  logic [2*DATA_W-1:0] rd_a_q, rd_b_q, b_word, a_data_q, b_data_q;
  logic [AW-1:0] raddr_q, idx_q, idx_d;
  logic [AW:0] a_cnt_q, b_cnt_q;
  logic valid_q, start_q, last_q, op_q, busy_q, done_q, wr_err_q, cmd_err_q;
  logic idle, clr_now, sel_full, wr_ok, accept, adv, fin, rd_en;
  assign idle     = state_q == IDLE;
  assign clr_now  = wr_clr & idle;
  assign sel_full = wr_sel ? b_cnt_q == FULL : a_cnt_q == FULL;
  assign wr_ok    = wr_en & ~clr_now & idle & ~sel_full;
  assign accept   = cmd_start & idle & a_cnt_q == FULL & b_cnt_q == FULL;
  // both pipeline stages (RAM read register and output register) advance together
  assign adv      = state_q == STREAM & (~valid_q | out_ready);
  assign fin      = state_q == STREAM & valid_q & out_ready & last_q;
  assign rd_en    = state_q == PRIME | adv;
  assign idx_d    = valid_q ? idx_q + AW'(1) : '0;
`ifdef FEEDER_CONJ_B_EN
  logic [DATA_W-1:0] b_im;
  assign b_im   = rd_b_q[DATA_W-1:0];
  assign b_word = {rd_b_q[2*DATA_W-1:DATA_W],
                   b_im == {1'b1, {(DATA_W-1){1'b0}}} ? {1'b0, {(DATA_W-1){1'b1}}} : -b_im};
`else
  assign b_word = rd_b_q;
`endif
  always_comb begin
    state_d = accept ? PRIME :
              state_q == PRIME ? STREAM :
              fin ? FINISH :
              state_q == FINISH ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (wr_ok & ~wr_sel) mem_a[a_cnt_q[AW-1:0]] <= wr_data;
    if (wr_ok & wr_sel) mem_b[b_cnt_q[AW-1:0]] <= wr_data;
    if (rd_en) begin
      rd_a_q <= mem_a[raddr_q];
      rd_b_q <= mem_b[raddr_q];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      raddr_q   <= '0;
      idx_q     <= '0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      op_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_err_q  <= wr_en & ~clr_now & (~idle | sel_full);
      cmd_err_q <= cmd_start & ~accept;
      done_q    <= fin;
      busy_q    <= accept | (busy_q & ~fin);
      if (clr_now) begin
        a_cnt_q <= '0;
        b_cnt_q <= '0;
      end else if (wr_ok) begin
        if (wr_sel) b_cnt_q <= b_cnt_q + (AW+1)'(1);
        else a_cnt_q <= a_cnt_q + (AW+1)'(1);
      end
      if (accept) begin
        op_q    <= cmd_op;
        raddr_q <= '0;
      end else if (rd_en) raddr_q <= raddr_q + AW'(1);
      if (fin) begin
        valid_q <= 1'b0;
        start_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (adv) begin
        valid_q  <= 1'b1;
        a_data_q <= rd_a_q;
        b_data_q <= b_word;
        idx_q    <= idx_d;
        start_q  <= ~valid_q;
        last_q   <= &idx_d;
      end
    end
  end
  assign a_data    = a_data_q;
  assign b_data    = b_data_q;
  assign a_valid   = valid_q;
  assign b_valid   = valid_q;
  assign start     = start_q;
  assign last      = last_q;
  assign operation = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;
  assign wr_err    = wr_err_q;
  assign cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_complex_operand_feeder.sv
// tb_complex_operand_feeder: randomized self-checking bench against an array-based reference model
module tb_complex_operand_feeder;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst, wr_en, wr_sel, wr_clr, cmd_start, cmd_op, out_ready;
  logic [31:0] wr_data, a_data, b_data;
  logic a_valid, b_valid, start, last, operation, busy, done, wr_err, cmd_err;
  logic [4:0] a_cnt, b_cnt;
  int checks = 0, failures = 0;
  logic [31:0] ma [D];
  logic [31:0] mb [D];
  int na = 0, nb = 0;
  always #5 clk = ~clk;
  complex_operand_feeder #(.DATA_W(16), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_clr(wr_clr),
    .cmd_start(cmd_start), .cmd_op(cmd_op), .out_ready(out_ready),
    .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
    .start(start), .last(last), .operation(operation), .busy(busy), .done(done),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .wr_err(wr_err), .cmd_err(cmd_err));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_b(input logic [31:0] w);
`ifdef FEEDER_CONJ_B_EN
    int v;
    v = -int'($signed(w[15:0]));
    if (v > 32767) v = 32767;
    return {w[31:16], 16'(v)};
`else
    return w;
`endif
  endfunction
  task automatic write(input logic sel, input logic [31:0] d);
    bit full;
    full = sel ? nb == D : na == D;
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick;
    wr_en = 1'b0;
    check("wr_err", wr_err, full);
    if (!full) begin
      if (sel) begin mb[nb] = d; nb++; end
      else begin ma[na] = d; na++; end
    end
    check("a_cnt", a_cnt, na);
    check("b_cnt", b_cnt, nb);
  endtask
  // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready
  task automatic run(input logic op, input int mode, input bit poke);
    int cyc, idx, first, hs, last_edge;
    bit got_done, rdy;
    cyc = 0; idx = 0; first = -1; hs = 0; last_edge = -1; got_done = 0;
    cmd_op = op; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_cmd_err", cmd_err, 0);
    while (!got_done && cyc < 300) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      cmd_start = poke && cyc == 5;
      check("busy_run", busy, 1);
      if (a_valid) begin
        if (first < 0) first = cyc;
        check("idx_range", idx < D, 1);
        check("a_data", a_data, ma[idx % D]);
        check("b_data", b_data, exp_b(mb[idx % D]));
        check("b_valid", b_valid, 1);
        check("start", start, idx == 0);
        check("last", last, idx == D - 1);
        check("operation", operation, op);
        if (mode == 0 && idx == D - 1) check("last_time", cyc, D + 1);
        if (rdy) begin
          if (idx == D - 1) last_edge = cyc + 1;
          idx++;
          hs++;
        end
      end
      tick;
      cyc++;
      cmd_start = 1'b0;
      if (poke && cyc == 6) check("busy_cmd_err", cmd_err, 1);
      if (done) begin
        got_done = 1;
        check("done_after_last", cyc, last_edge);
        check("done_valid", a_valid, 0);
        check("done_busy", busy, 0);
        if (mode == 0) check("done_time", cyc, D + 2);
      end
    end
    check("first_valid", first, 2);
    check("handshakes", hs, D);
    check("done_seen", got_done, 1);
    out_ready = 1'b0;
    tick;
    check("done_pulse", done, 0);
  endtask
  initial begin
    int hs, cyc;
    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_clr = 0; wr_data = 0;
    cmd_start = 0; cmd_op = 0; out_ready = 0;
    repeat (2) tick;
    check("rst_valid", a_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_acnt", a_cnt, 0);
    check("rst_bcnt", b_cnt, 0);
    check("rst_op", operation, 0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < D; i++) write(0, {16'(i), 16'(-i)});
    for (int i = 0; i < D; i++) write(1, {16'(2 * i), 16'(i)});
    write(0, 32'hdead_beef);
    tick;
    check("wr_err_pulse", wr_err, 0);
    run(1'b1, 0, 1'b1);
    run(1'b0, 1, 1'b0);
    wr_clr = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h1234_5678;
    tick;
    wr_clr = 1'b0; wr_en = 1'b0; na = 0; nb = 0;
    check("clr_acnt", a_cnt, 0);
    check("clr_bcnt", b_cnt, 0);
    check("clr_wr_err", wr_err, 0);
    for (int i = 0; i < D; i++) write(0, $urandom);
    write(1, {16'($urandom), 16'h8000});
    write(1, {16'($urandom), 16'd5});
    write(1, {16'($urandom), 16'h7fff});
    for (int i = 3; i < D - 1; i++) write(1, $urandom);
    cmd_op = 1'b1; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    check("partial_cmd_err", cmd_err, 1);
    check("partial_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("partial_no_valid", a_valid, 0);
    end
    write(1, $urandom);
    run(1'($urandom_range(0, 1)), 2, 1'b0);
    cmd_op = 1'b1; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0; out_ready = 1'b1; hs = 0; cyc = 0;
    while (hs < 6 && cyc < 50) begin
      if (a_valid) hs++;
      tick;
      cyc++;
    end
    check("pre_reset_hs", hs, 6);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {a_valid, b_valid, start, last}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", {a_cnt, b_cnt}, 0);
    check("mid_rst_data", {a_data, b_data}, 0);
    check("mid_rst_misc", {operation, done, wr_err, cmd_err}, 0);
    tick;
    rst = 1'b0; out_ready = 1'b0;
    tick;
    check("post_rst_valid", a_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
